lsu_gpr_writeback_sequencer: RTL
================================

// Module: lsu_gpr_writeback_sequencer
// PURPOSE
//  Consumer end of the LSU opcode-decode fields. Latches one decoded memory op
//  (rd/wr, gpr target, op depth, SGPR write mask, dest base), then sequences the
//  returned memory beats into SGPR/VGPR destination writes. Emits a one-cycle
//  retire pulse per op. Sits between the LSU memory response path and the GPR
//  write ports; one op in flight at a time.
// PARAMETERS
//  SGPR_DATA_W  128   data per SGPR beat (4 dwords)
//  VGPR_DATA_W  2048  data per VGPR beat (64 lanes x 32b)
// PORTS
//  clk              in   1     clock
//  rst              in   1     async reset, active-high
//  req_valid        in   1     decoded op offered
//  req_ready        out  1     op accepted when req_valid & req_ready
//  req_rd           in   1     mem_op_rd from decoder
//  req_wr           in   1     mem_op_wr from decoder
//  req_gpr          in   1     0 = SGPR target, 1 = VGPR target
//  req_op_depth     in   2     gpr_op_depth; beats = depth+1
//  req_sgpr_mask    in   4     sgpr_wr_mask, used only for depth 0
//  req_dest_addr    in   10    dest base; SGPR uses [8:0]
//  req_wfid         in   6     wavefront id
//  req_exec         in   64    lane mask for VGPR writes
//  mem_ack          in   1     one response beat / store completion
//  mem_rd_data      in   VGPR_DATA_W  beat data; SGPR beats use [SGPR_DATA_W-1:0]
//  sgpr_wr_en       out  4     per-dword SGPR write enable
//  sgpr_wr_addr     out  9     SGPR write address
//  sgpr_wr_data     out  SGPR_DATA_W
//  vgpr_wr_en       out  1     VGPR write strobe
//  vgpr_wr_addr     out  10    VGPR write address
//  vgpr_wr_mask     out  64    lane enables (= latched req_exec)
//  vgpr_wr_data     out  VGPR_DATA_W
//  retire_valid     out  1     one-cycle op-complete pulse
//  retire_wfid      out  6     wfid of retiring op
//  spurious_ack     out  1     one-cycle pulse: mem_ack with no op waiting
// BEHAVIOUR
//  - Reset (async): state IDLE, beat_cnt=0, every output 0 except req_ready=1.
//  - FSM IDLE -> WAIT on accept; WAIT -> IDLE after the final ack. req_ready=1 only in IDLE.
//  - Accept latches all req_* fields. req_rd & req_wr both set: rd wins.
//  - Neither rd nor wr set: no mem wait; retire_valid at accept+1, back to IDLE.
//  - Load: expects depth+1 acks. Each ack at cycle T gives registered writes at T+1.
//    SGPR beat b: addr = base[8:0] + 4*b (mod 512); data = mem_rd_data[127:0];
//    en = req_sgpr_mask if depth==0, else 4'b1111.
//    VGPR beat b: addr = base + b (mod 1024); mask = exec; data = full beat.
//  - Store: first ack completes the op regardless of depth; no GPR write.
//  - Final ack at T: retire_valid=1 at T+1 (coincident with last write); IDLE at T+1.
//    New req can be accepted at T+1 itself (req_ready=1 from T+1), so a new accept
//    and a retire in the same cycle are allowed.
//  - Write enables and retire_valid are single-cycle; they drop to 0 the next cycle
//    unless another ack arrives.
//  - mem_ack in IDLE: ignored; spurious_ack pulses at T+1; no state change.
//  - Back-to-back acks (every cycle) are supported; no beat is dropped.
//  - beat_cnt is 2 bits and resets to 0 on accept.
//  - Reset mid-op: op is discarded; no retire; pending write enables cleared.
// TESTING
//  1. SGPR s_load_dword: depth 0, mask 0001, base 0x010; ack data 0xA5 ->
//     next cycle sgpr_wr_en=0001, addr 0x010, retire_valid=1.
//  2. SGPR x16: depth 2, base 0x020; 3 back-to-back acks -> en=1111 at
//     addrs 0x020/0x024/0x028; retire coincident with the 3rd write.
//  3. VGPR tbuffer_load_xyzw: depth 3, base 0x3FE, exec 0xF0F0...; 4 acks ->
//     addrs 0x3FE, 0x3FF, 0x000, 0x001 (wrap); vgpr_wr_mask = exec every beat.
//  4. Store: wr, depth 3, one ack -> no wr_en ever; retire next cycle, wfid matches.
//  5. Spurious ack in IDLE -> spurious_ack pulse, no writes; then assert rst
//     mid-load after 1 of 2 beats -> outputs 0, req_ready=1, no retire.
//  6. Retire/accept overlap: hold req_valid high across the final ack -> 2nd op is
//     accepted in the retire cycle, and its first beat targets its own base address.

Source files
------------

// File: rtl/lsu_gpr_writeback_sequencer.sv
// -----------------------------------------------------------------------------
// lsu_gpr_writeback_sequencer
//
// Purpose:
//   Consumer end of the LSU opcode-decode fields. Accepts one decoded memory
//   op at a time, then turns the returned memory beats into SGPR or VGPR
//   destination writes. Each op ends with a one-cycle retire pulse.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_*              decoded op handshake and fields (latched on accept)
//   mem_ack            one response beat (load) or store completion
//   mem_rd_data        beat data; SGPR beats use the low SGPR_DATA_W bits
//   sgpr_wr_*          registered SGPR write port (per-dword enables)
//   vgpr_wr_*          registered VGPR write port (lane mask = latched exec)
//   retire_valid/wfid  one-cycle op-complete pulse and its wavefront id
//   spurious_ack       one-cycle pulse when mem_ack arrives with no op waiting
// -----------------------------------------------------------------------------
module lsu_gpr_writeback_sequencer #(
  parameter int SGPR_DATA_W = 128,
  parameter int VGPR_DATA_W = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rd,
  input  logic                   req_wr,
  input  logic                   req_gpr,
  input  logic [1:0]             req_op_depth,
  input  logic [3:0]             req_sgpr_mask,
  input  logic [9:0]             req_dest_addr,
  input  logic [5:0]             req_wfid,
  input  logic [63:0]            req_exec,
  input  logic                   mem_ack,
  input  logic [VGPR_DATA_W-1:0] mem_rd_data,
  output logic [3:0]             sgpr_wr_en,
  output logic [8:0]             sgpr_wr_addr,
  output logic [SGPR_DATA_W-1:0] sgpr_wr_data,
  output logic                   vgpr_wr_en,
  output logic [9:0]             vgpr_wr_addr,
  output logic [63:0]            vgpr_wr_mask,
  output logic [VGPR_DATA_W-1:0] vgpr_wr_data,
  output logic                   retire_valid,
  output logic [5:0]             retire_wfid,
  output logic                   spurious_ack
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             beat_cnt_q, beat_cnt_d;

  // Latched op fields. Only rd is kept: once waiting, !rd means store.
  logic                   op_rd_q, op_rd_d;
  logic                   op_gpr_q, op_gpr_d;
  logic [1:0]             op_depth_q, op_depth_d;
  logic [3:0]             op_mask_q, op_mask_d;
  logic [9:0]             op_base_q, op_base_d;
  logic [5:0]             op_wfid_q, op_wfid_d;
  logic [63:0]            op_exec_q, op_exec_d;

  // Registered write-port / pulse outputs.
  logic [3:0]             sgpr_en_q, sgpr_en_d;
  logic [8:0]             sgpr_addr_q, sgpr_addr_d;
  logic [SGPR_DATA_W-1:0] sgpr_data_q, sgpr_data_d;
  logic                   vgpr_en_q, vgpr_en_d;
  logic [9:0]             vgpr_addr_q, vgpr_addr_d;
  logic [63:0]            vgpr_mask_q, vgpr_mask_d;
  logic [VGPR_DATA_W-1:0] vgpr_data_q, vgpr_data_d;
  logic                   retire_q, retire_d;
  logic [5:0]             retire_wfid_q, retire_wfid_d;
  logic                   spurious_q, spurious_d;

  logic                   last_beat;

  assign req_ready = (state_q == ST_IDLE);

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    op_rd_d       = op_rd_q;
    op_gpr_d      = op_gpr_q;
    op_depth_d    = op_depth_q;
    op_mask_d     = op_mask_q;
    op_base_d     = op_base_q;
    op_wfid_d     = op_wfid_q;
    op_exec_d     = op_exec_q;
    sgpr_addr_d   = sgpr_addr_q;
    sgpr_data_d   = sgpr_data_q;
    vgpr_addr_d   = vgpr_addr_q;
    vgpr_mask_d   = vgpr_mask_q;
    vgpr_data_d   = vgpr_data_q;
    retire_wfid_d = retire_wfid_q;
    // Strobes and pulses fall back to 0 every cycle.
    sgpr_en_d     = 4'b0000;
    vgpr_en_d     = 1'b0;
    retire_d      = 1'b0;
    spurious_d    = 1'b0;
    last_beat     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_ack) begin
          spurious_d = 1'b1;
        end
        if (req_valid) begin
          op_rd_d    = req_rd;
          op_gpr_d   = req_gpr;
          op_depth_d = req_op_depth;
          op_mask_d  = req_sgpr_mask;
          op_base_d  = req_dest_addr;
          op_wfid_d  = req_wfid;
          op_exec_d  = req_exec;
          beat_cnt_d = 2'd0;
          if (req_rd || req_wr) begin
            state_d = ST_WAIT;
          end else begin
            // No memory traffic: retire straight away and stay idle.
            retire_d      = 1'b1;
            retire_wfid_d = req_wfid;
          end
        end
      end

      ST_WAIT: begin
        if (mem_ack) begin
          if (op_rd_q) begin
            if (op_gpr_q) begin
              vgpr_en_d   = 1'b1;
              vgpr_addr_d = op_base_q + 10'(beat_cnt_q);
              vgpr_mask_d = op_exec_q;
              vgpr_data_d = mem_rd_data;
            end else begin
              // SGPR beats are four dwords wide, so the address steps by 4.
              sgpr_en_d   = (op_depth_q == 2'd0) ? op_mask_q : 4'b1111;
              sgpr_addr_d = op_base_q[8:0] + {5'd0, beat_cnt_q, 2'b00};
              sgpr_data_d = mem_rd_data[SGPR_DATA_W-1:0];
            end
            last_beat = (beat_cnt_q == op_depth_q);
          end else begin
            // Store: the single completion ack ends the op.
            last_beat = 1'b1;
          end
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (last_beat) begin
            retire_d      = 1'b1;
            retire_wfid_d = op_wfid_q;
            state_d       = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the wide data registers are reset too, so all outputs read 0 after
  // reset rather than X, at the cost of reset fan-out on those flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= 2'd0;
      op_rd_q       <= 1'b0;
      op_gpr_q      <= 1'b0;
      op_depth_q    <= 2'd0;
      op_mask_q     <= 4'b0000;
      op_base_q     <= 10'd0;
      op_wfid_q     <= 6'd0;
      op_exec_q     <= 64'd0;
      sgpr_en_q     <= 4'b0000;
      sgpr_addr_q   <= 9'd0;
      sgpr_data_q   <= '0;
      vgpr_en_q     <= 1'b0;
      vgpr_addr_q   <= 10'd0;
      vgpr_mask_q   <= 64'd0;
      vgpr_data_q   <= '0;
      retire_q      <= 1'b0;
      retire_wfid_q <= 6'd0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      op_rd_q       <= op_rd_d;
      op_gpr_q      <= op_gpr_d;
      op_depth_q    <= op_depth_d;
      op_mask_q     <= op_mask_d;
      op_base_q     <= op_base_d;
      op_wfid_q     <= op_wfid_d;
      op_exec_q     <= op_exec_d;
      sgpr_en_q     <= sgpr_en_d;
      sgpr_addr_q   <= sgpr_addr_d;
      sgpr_data_q   <= sgpr_data_d;
      vgpr_en_q     <= vgpr_en_d;
      vgpr_addr_q   <= vgpr_addr_d;
      vgpr_mask_q   <= vgpr_mask_d;
      vgpr_data_q   <= vgpr_data_d;
      retire_q      <= retire_d;
      retire_wfid_q <= retire_wfid_d;
      spurious_q    <= spurious_d;
    end
  end

  assign sgpr_wr_en   = sgpr_en_q;
  assign sgpr_wr_addr = sgpr_addr_q;
  assign sgpr_wr_data = sgpr_data_q;
  assign vgpr_wr_en   = vgpr_en_q;
  assign vgpr_wr_addr = vgpr_addr_q;
  assign vgpr_wr_mask = vgpr_mask_q;
  assign vgpr_wr_data = vgpr_data_q;
  assign retire_valid = retire_q;
  assign retire_wfid  = retire_wfid_q;
  assign spurious_ack = spurious_q;

endmodule
